// File: rtl/wb_select_pkg.sv
// Shared selection codes and hard-wired constants for the register-file
// write-back select stage.
package wb_select_pkg;

    localparam int SEL_SRC0         = 0;
    localparam int SEL_SRC1         = 1;
    localparam int SEL_SRC2         = 2;
    localparam int SEL_CONST_A      = 3;
    localparam int SEL_CONST_B      = 4;
    localparam int SEL_ONES         = 5;
    localparam int SEL_PC           = 6;
    localparam int SEL_SRC3         = 7;
    localparam int SEL_LINK         = 8;
    localparam int SEL_SRC_EXT_BASE = 9;

    localparam int CONST_A = 95;
    localparam int CONST_B = 200;

endpackage

// File: rtl/wb_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer: a main register drives the
// outputs and a skid register absorbs one beat while main is stalled.
module wb_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    // Handshake: a beat transfers on any rising edge where valid && ready;
    // valid never depends on ready, and payload holds while valid && !ready.
    logic         main_valid;
    logic         skid_valid;
    logic [W-1:0] main_data;
    logic [W-1:0] skid_data;
    logic         accept;
    logic         deliver;

    assign in_ready  = !skid_valid;
    assign accept    = in_valid && in_ready;
    assign deliver   = main_valid && out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (deliver) begin
            // skid_valid implies in_ready is low, so no accept can coincide
            if (skid_valid) begin
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_data  <= in_data;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            if (!main_valid) begin
                main_data  <= in_data;
                main_valid <= 1'b1;
            end else begin
                skid_data  <= in_data;
                skid_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_select_stage.sv
// Write-back select stage: decodes the selection code at accept time and
// registers {illegal, dest, data} through a 2-entry skid buffer.
module wb_select_stage
    import wb_select_pkg::*;
#(
    parameter int DATA_W      = 17,
    parameter int NUM_SRC     = 4,
    parameter int SEL_W       = 4,
    parameter int REG_W       = 3,
    parameter int LINK_OFFSET = 1
) (
    input  logic                      Clock,
    input  logic                      Reset_n,
    input  logic                      InValid,
    output logic                      InReady,
    input  logic [NUM_SRC*DATA_W-1:0] Sources,
    input  logic [DATA_W-1:0]         PC,
    input  logic [SEL_W-1:0]          Selection,
    input  logic [REG_W-1:0]          DestReg,
    output logic                      OutValid,
    input  logic                      OutReady,
    output logic [DATA_W-1:0]         OutData,
    output logic [REG_W-1:0]          OutDest,
    output logic                      OutIllegal,
    output logic [7:0]                IllegalCount
);

    localparam int PW = 1 + REG_W + DATA_W;

    logic [DATA_W-1:0] src [NUM_SRC];
    logic [DATA_W-1:0] link_value;
    logic [DATA_W-1:0] dec_data;
    logic              dec_illegal;
    logic [PW-1:0]     in_payload;
    logic [PW-1:0]     out_payload;
    logic [7:0]        illegal_count;
    logic              accept;
    int                sel_i;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign src[g] = Sources[g*DATA_W +: DATA_W];
    end

    assign sel_i      = int'(Selection);
    assign link_value = PC + DATA_W'(LINK_OFFSET);

    always_comb begin
        dec_data    = '0;
        dec_illegal = 1'b0;
        case (sel_i)
            SEL_SRC0:    dec_data = src[0];
            SEL_SRC1:    dec_data = src[1];
            SEL_SRC2:    dec_data = src[2];
            SEL_CONST_A: dec_data = DATA_W'(CONST_A);
            SEL_CONST_B: dec_data = DATA_W'(CONST_B);
            SEL_ONES:    dec_data = '1;
            SEL_PC:      dec_data = PC;
            SEL_SRC3:    dec_data = src[3];
            SEL_LINK:    dec_data = link_value;
            default: begin
                // Codes above SEL_LINK map onto the extra sources, if any
                dec_illegal = 1'b1;
                for (int i = 4; i < NUM_SRC; i++) begin
                    if (sel_i == SEL_SRC_EXT_BASE + i - 4) begin
                        dec_data    = src[i];
                        dec_illegal = 1'b0;
                    end
                end
            end
        endcase
    end

    assign in_payload = {dec_illegal, DestReg, dec_data};
    assign accept     = InValid && InReady;

    wb_skid_buffer #(
        .W(PW)
    ) u_skid (
        .clk      (Clock),
        .rst_n    (Reset_n),
        .in_valid (InValid),
        .in_ready (InReady),
        .in_data  (in_payload),
        .out_valid(OutValid),
        .out_ready(OutReady),
        .out_data (out_payload)
    );

    assign {OutIllegal, OutDest, OutData} = out_payload;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            illegal_count <= '0;
        end else if (accept && dec_illegal && illegal_count != 8'hFF) begin
            illegal_count <= illegal_count + 8'd1;
        end
    end

    assign IllegalCount = illegal_count;

endmodule

// File: tb/tb_wb_select_stage.sv
// Bench for wb_select_stage: table-driven decode vectors, scoreboarded
// output stream, stall, back-to-back flow and asynchronous reset sequences.
module tb_wb_select_stage;

    localparam int DATA_W  = 17;
    localparam int NUM_SRC = 4;
    localparam int SEL_W   = 4;
    localparam int REG_W   = 3;
    localparam int PW      = 1 + REG_W + DATA_W;

    logic                      Clock = 1'b0;
    logic                      Reset_n;
    logic                      InValid;
    logic                      InReady;
    logic [NUM_SRC*DATA_W-1:0] Sources;
    logic [DATA_W-1:0]         PC;
    logic [SEL_W-1:0]          Selection;
    logic [REG_W-1:0]          DestReg;
    logic                      OutValid;
    logic                      OutReady;
    logic [DATA_W-1:0]         OutData;
    logic [REG_W-1:0]          OutDest;
    logic                      OutIllegal;
    logic [7:0]                IllegalCount;

    wb_select_stage #(
        .DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .REG_W(REG_W), .LINK_OFFSET(1)
    ) dut (
        .Clock(Clock), .Reset_n(Reset_n), .InValid(InValid), .InReady(InReady),
        .Sources(Sources), .PC(PC), .Selection(Selection), .DestReg(DestReg),
        .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData), .OutDest(OutDest),
        .OutIllegal(OutIllegal), .IllegalCount(IllegalCount)
    );

    // ---------------- clock / reset ----------------
    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int            tests = 0;
    int            fails = 0;
    logic [PW-1:0] exp_q[$];
    int            acc_q[$];
    int            acc_cnt = 0;
    int            deliv_cnt = 0;
    bit            lat_chk = 1'b0;
    bit            prev_stall = 1'b0;
    logic [PW-1:0] prev_pl;

    typedef struct {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] d;
        logic              ill;
    } vec_t;
    vec_t tv[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output monitor: pops expected beats on every delivery
    always @(negedge Clock) begin
        logic [PW-1:0] e;
        int            c;
        if (!Reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && OutValid)
                check("stall_hold", 32'({OutIllegal, OutDest, OutData}), 32'(prev_pl));
            prev_stall = OutValid && !OutReady;
            prev_pl    = {OutIllegal, OutDest, OutData};
            if (OutValid && OutReady) begin
                deliv_cnt++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got dest %0d data %0h, expected no beat", OutDest, OutData);
                end else begin
                    e = exp_q.pop_front();
                    c = acc_q.pop_front();
                    check("out_data", 32'(OutData), 32'(e[DATA_W-1:0]));
                    check("out_dest", 32'(OutDest), 32'(e[DATA_W +: REG_W]));
                    check("out_illegal", 32'(OutIllegal), 32'(e[PW-1]));
                    if (lat_chk) check("latency", cyc - c, 1);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [SEL_W-1:0] sel, input logic [REG_W-1:0] dest,
                        input logic [DATA_W-1:0] pc, input logic [DATA_W-1:0] ed, input logic ei);
        int tries = 0;
        Selection = sel;
        DestReg   = dest;
        PC        = pc;
        InValid   = 1'b1;
        forever begin
            @(negedge Clock);
            if (InReady) begin
                exp_q.push_back({ei, dest, ed});
                acc_q.push_back(cyc);
                acc_cnt++;
                break;
            end
            tries++;
            if (tries > 50) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout: got no accept in 50 cycles, expected accept");
                break;
            end
        end
        @(posedge Clock);
        #1;
        InValid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge Clock);
            n++;
        end
        @(posedge Clock);
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int d0;
        int a0;
        Reset_n   = 1'b0;
        InValid   = 1'b0;
        OutReady  = 1'b1;
        Sources   = {17'h00044, 17'h00033, 17'h00022, 17'h00011};
        PC        = '0;
        Selection = '0;
        DestReg   = '0;

        tv[0] = '{4'd0, 17'h00100, 17'h00011, 1'b0};
        tv[1] = '{4'd1, 17'h00100, 17'h00022, 1'b0};
        tv[2] = '{4'd2, 17'h00100, 17'h00033, 1'b0};
        tv[3] = '{4'd3, 17'h00100, 17'd95,    1'b0};
        tv[4] = '{4'd4, 17'h00100, 17'd200,   1'b0};
        tv[5] = '{4'd5, 17'h00100, 17'h1FFFF, 1'b0};
        tv[6] = '{4'd6, 17'h00100, 17'h00100, 1'b0};
        tv[7] = '{4'd7, 17'h00100, 17'h00044, 1'b0};
        tv[8] = '{4'd8, 17'h00100, 17'h00101, 1'b0};
        tv[9] = '{4'd8, 17'h1FFFF, 17'h00000, 1'b0};
        for (int i = 9; i <= 15; i++) tv[i+1] = '{4'(i), 17'h00100, 17'h00000, 1'b1};

        repeat (3) @(posedge Clock);
        #1;
        check("rst_out_valid", 32'(OutValid), 0);
        check("rst_out_data", 32'(OutData), 0);
        check("rst_out_dest", 32'(OutDest), 0);
        check("rst_out_illegal", 32'(OutIllegal), 0);
        check("rst_illegal_count", 32'(IllegalCount), 0);
        check("rst_in_ready", 32'(InReady), 1);
        Reset_n = 1'b1;
        @(posedge Clock);
        #1;

        // Decode table, streamed back to back
        lat_chk = 1'b1;
        for (int i = 0; i < 17; i++) send(tv[i].sel, 3'(i), tv[i].pc, tv[i].d, tv[i].ill);
        drain();
        lat_chk = 1'b0;
        check("illegal_count_7", 32'(IllegalCount), 7);

        // Saturation of the illegal counter
        for (int i = 0; i < 300; i++) send(4'(9 + (i % 7)), 3'(i), 17'h00100, 17'h0, 1'b1);
        drain();
        check("illegal_count_sat", 32'(IllegalCount), 255);

        // Downstream stall in the middle of a 6-beat stream
        d0 = deliv_cnt;
        a0 = acc_cnt;
        fork
            begin
                for (int i = 0; i < 6; i++) send(tv[i].sel, 3'(i), tv[i].pc, tv[i].d, tv[i].ill);
            end
            begin
                int n = 0;
                while (acc_cnt < a0 + 2 && n < 50) begin
                    @(posedge Clock);
                    n++;
                end
                #1;
                OutReady = 1'b0;
                @(negedge Clock); check("stall_in_ready_0", 32'(InReady), 1);
                @(negedge Clock); check("stall_in_ready_1", 32'(InReady), 0);
                @(negedge Clock); check("stall_in_ready_2", 32'(InReady), 0);
                @(posedge Clock);
                #1;
                OutReady = 1'b1;
                @(negedge Clock); check("resume_in_ready_0", 32'(InReady), 0);
                @(negedge Clock); check("resume_in_ready_1", 32'(InReady), 1);
            end
        join
        drain();
        check("stall_beats_delivered", deliv_cnt - d0, 6);

        // Simultaneous accept and deliver, skid empty
        lat_chk = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(tv[i % 9].sel, 3'(i), tv[i % 9].pc, tv[i % 9].d, tv[i % 9].ill);
            if (i > 0) begin
                check("flow_out_valid", 32'(OutValid), 1);
                check("flow_in_ready", 32'(InReady), 1);
            end
        end
        drain();
        lat_chk = 1'b0;

        // Asynchronous reset with both entries full
        OutReady = 1'b0;
        send(4'd15, 3'd1, 17'h00100, 17'h0, 1'b1);
        send(4'd15, 3'd2, 17'h00100, 17'h0, 1'b1);
        check("full_in_ready", 32'(InReady), 0);
        check("full_out_valid", 32'(OutValid), 1);
        #2;
        Reset_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(OutValid), 0);
        check("async_rst_in_ready", 32'(InReady), 1);
        check("async_rst_illegal_count", 32'(IllegalCount), 0);
        exp_q.delete();
        acc_q.delete();
        @(posedge Clock);
        #1;
        Reset_n  = 1'b1;
        OutReady = 1'b1;
        d0 = deliv_cnt;
        send(4'd6, 3'd3, 17'h01234, 17'h01234, 1'b0);
        drain();
        check("post_rst_single_beat", deliv_cnt - d0, 1);
        check("post_rst_idle", 32'(OutValid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
